// File: rtl/topk_drain.sv
// Streaming top-K collector: keeps the K largest samples sorted descending,
// then drains them largest-first over valid/ready and clears.
module topk_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     in_ready,
  input  logic                     drain,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(K+1)-1:0]   count
);

  localparam int CW = $clog2(K+1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] slot_q [K];
  logic [DATA_WIDTH-1:0] slot_d [K];
  logic [K-1:0]          ge;

  // ge is a prefix mask: occupied slots that stay ahead of din (ties too)
  always_comb begin
    for (int i = 0; i < K; i++) begin
      ge[i] = (CW'(i) < count_q) && (slot_q[i] >= din);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    for (int i = 0; i < K; i++) begin
      slot_d[i] = slot_q[i];
    end
    unique case (1'b1)
      (state_q == COLLECT): begin
        if (in_valid && !ge[K-1]) begin
          if (!ge[0]) slot_d[0] = din;
          for (int i = 1; i < K; i++) begin
            if (!ge[i]) slot_d[i] = ge[i-1] ? din : slot_q[i-1];
          end
          if (count_q != CW'(K)) count_d = count_q + CW'(1);
        end
        if (drain && count_d != '0) state_d = DRAIN;
      end
      (state_q == DRAIN): begin
        if (out_ready) begin
          for (int i = 0; i < K-1; i++) begin
            slot_d[i] = slot_q[i+1];
          end
          slot_d[K-1] = '0;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = COLLECT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= COLLECT;
      count_q <= '0;
      for (int i = 0; i < K; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < K; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == DRAIN);
  assign dout      = slot_q[0];
  assign out_last  = out_valid && (count_q == CW'(1));
  assign count     = count_q;

endmodule

// File: tb/tb_topk_drain.sv
// Scoreboard bench for topk_drain (K=4, 8-bit data): expected drain beats
// are queued by the stimulus and checked by an independent monitor.
module tb_topk_drain;

  localparam int DW = 8;
  localparam int K  = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic [2:0]    cnt;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          in_ready;
  logic          drain = 1'b0;
  logic          out_valid;
  logic [DW-1:0] dout;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic [2:0]    count;

  int n_chk  = 0;
  int n_fail = 0;
  beat_t exp_q[$];

  topk_drain #(.DATA_WIDTH(DW), .K(K)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .din(din), .in_ready(in_ready),
    .drain(drain), .out_valid(out_valid), .dout(dout),
    .out_last(out_last), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: a beat is presented mid-cycle and completes at the next edge
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", int'(dout), -1);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", int'(dout), int'(e.d));
        chk("beat_last", int'(out_last), int'(e.last));
        chk("beat_count", int'(count), int'(e.cnt));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    in_valid = 1'b1;
    din = v;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l, input int c);
    beat_t b;
    b.d = d;
    b.last = l;
    b.cnt = 3'(c);
    exp_q.push_back(b);
  endtask

  task automatic wait_empty();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      cyc();
      budget++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_count"}, int'(count), 0);
  endtask

  initial begin
    logic       pat [5];
    logic [7:0] hold [5];
    logic       hlast [5];

    // reset state
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    idle_chk("rst");
    chk("rst_dout", int'(dout), 0);
    chk("rst_last", int'(out_last), 0);

    // basic collection with duplicate and discard
    send(5); send(9); send(2); send(7); send(9); send(1);
    chk("t1_count", int'(count), 4);
    chk("t1_top", int'(dout), 9);
    push(9, 0, 4); push(9, 0, 3); push(7, 0, 2); push(5, 1, 1);
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    chk("t1_in_ready_drain", int'(in_ready), 0);
    chk("t1_out_valid", int'(out_valid), 1);
    wait_empty();
    idle_chk("t1_end");

    // full array: small sample discarded, tie inserted after equal entry
    send(10); send(20); send(30); send(40);
    send(5);
    chk("t2_count_disc", int'(count), 4);
    send(40);
    chk("t2_count", int'(count), 4);
    push(40, 0, 4); push(40, 0, 3); push(30, 0, 2); push(20, 1, 1);
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    wait_empty();
    idle_chk("t2_end");

    // consumer stalls
    send(3); send(8);
    push(8, 0, 2); push(3, 1, 1);
    pat   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    hold  = '{8'd8, 8'd8, 8'd3, 8'd3, 8'd3};
    hlast = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drain = 1'b1;
    out_ready = 1'b0;
    cyc();
    drain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i];
      chk("t3_hold_dout", int'(dout), int'(hold[i]));
      chk("t3_hold_last", int'(out_last), int'(hlast[i]));
      chk("t3_hold_valid", int'(out_valid), 1);
      cyc();
    end
    out_ready = 1'b1;
    chk("t3_left", exp_q.size(), 0);
    idle_chk("t3_end");

    // sample and drain in the same cycle
    send(10); send(20);
    push(50, 0, 3); push(20, 0, 2); push(10, 1, 1);
    in_valid = 1'b1;
    din = 50;
    drain = 1'b1;
    cyc();
    in_valid = 1'b0;
    drain = 1'b0;
    wait_empty();
    idle_chk("t4_end");

    // drain while empty is ignored
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    idle_chk("t5_empty");
    cyc();
    idle_chk("t5_empty2");

    // samples offered during DRAIN are not stored
    send(1); send(2);
    push(2, 0, 2); push(1, 1, 1);
    out_ready = 1'b0;
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    in_valid = 1'b1;
    din = 99;
    cyc();
    chk("t5_in_ready", int'(in_ready), 0);
    cyc();
    in_valid = 1'b0;
    chk("t5_count", int'(count), 2);
    out_ready = 1'b1;
    wait_empty();
    idle_chk("t5_end");

    // reset in the middle of a drain
    send(4); send(3); send(2); send(1);
    push(4, 0, 4);
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    cyc();
    resetn = 1'b0;
    out_ready = 1'b0;
    cyc();
    resetn = 1'b1;
    out_ready = 1'b1;
    chk("t6_left", exp_q.size(), 0);
    idle_chk("t6_rst");
    chk("t6_dout", int'(dout), 0);
    chk("t6_last", int'(out_last), 0);
    send(7);
    push(7, 1, 1);
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    wait_empty();
    idle_chk("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/topk_drain.md
Name: topk_drain

Overview:
- Streaming top-K collector with a read-out side.
- The write side accepts an unsigned data stream and keeps the K largest values seen, sorted in descending order.
- On a drain request, the read side emits the retained values largest-first over a valid/ready interface, then clears for the next collection window.
- Sits downstream of stream producers; feeds statistics/report logic that needs ranked values rather than a single running rank.

Parameters:
DATA_WIDTH, 32, width of each data word (unsigned).
K, 4, number of retained ranks (K >= 2).

Ports:
clk  input  1  clock; all state updates on rising edge.
resetn  input  1  synchronous, active-low reset.
in_valid  input  1  din carries a sample this cycle.
din  input  DATA_WIDTH  sample value.
in_ready  output  1  block accepts samples; high only in COLLECT.
drain  input  1  request to emit the retained values; sampled in COLLECT only.
out_valid  output  1  dout holds a valid ranked value.
dout  output  DATA_WIDTH  current largest retained value (slot 0).
out_last  output  1  high with out_valid on the final beat of a drain.
out_ready  input  1  consumer accepts dout this cycle.
count  output  $clog2(K+1)  number of occupied slots, 0..K.

Behaviour:
- Storage: slot[0..K-1] registers, kept sorted descending. Slot 0 is the largest. Only slots 0..count-1 are meaningful; unused slots hold 0.
- Reset (resetn low at a clock edge): state=COLLECT, all slots=0, count=0.
- Post-reset outputs: out_valid=0, out_last=0, dout=0, in_ready=1.
- Inputs are ignored in any cycle where resetn is low.
- States: COLLECT, DRAIN.
  - in_ready = (state==COLLECT).
  - out_valid = (state==DRAIN).
  - dout = slot[0] at all times.
  - out_last = out_valid && count==1.
- COLLECT, accepted sample (in_valid && in_ready):
  - Let p = number of occupied slots with value >= din. Compare is unsigned.
  - Ties: the new value goes after equal entries. Duplicates are kept as separate entries.
  - If p < K: din is written to slot[p], and slots p..K-2 shift down one place. The old slot[K-1] is dropped when count==K. count = min(count+1, K).
  - If p == K (array full and din <= slot[K-1]): sample discarded, no state change.
  - Insertion takes effect at the clock edge; single-cycle latency. One sample accepted per cycle, no back-pressure in COLLECT.
- COLLECT, drain high:
  - count>0: transition to DRAIN at the same edge.
  - If in_valid is also high in that cycle, the sample is inserted first. DRAIN then starts with the updated array, and count includes that sample.
  - count==0 and no sample accepted in the same cycle: drain ignored, stay in COLLECT, no output beats.
- DRAIN:
  - out_valid=1 and dout=slot[0].
  - A beat completes when out_valid && out_ready. On completion: slots shift up (slot[i] <= slot[i+1]), slot[K-1] <= 0, count decrements.
  - On the beat with out_last=1: return to COLLECT. Array is then all 0, count=0, and in_ready is high the next cycle.
  - out_ready low: dout, out_valid and out_last hold stable indefinitely.
  - drain and in_valid are ignored in DRAIN. in_ready=0, so no samples are lost silently; the producer must stall.
- Reset mid-drain: abort immediately. Remaining values are discarded, and outputs take reset values on the next cycle.
- count never exceeds K and never underflows.

Test Plan:
- Reset, then K=4, DATA_WIDTH=8, samples 5,9,2,7,9,1, drain, out_ready=1 -> beats 9,9,7,5. out_last only on the 5 beat. count goes 4,3,2,1,0. in_ready returns 1 the cycle after the last beat.
- Fill with 10,20,30,40, then samples 5 and 40 -> 5 discarded (count stays 4). 40 is inserted and 10 dropped. Drain yields 40,40,30,20.
- Samples 3,8 then drain with out_ready toggling 0,1,0,0,1 -> dout holds 8 while stalled, then 3 with out_last=1. Exactly 2 beats, no duplication.
- Cycle with in_valid=1, din=50 and drain=1 together, existing entries 10,20 -> drain emits 50,20,10, count 3 at drain start.
- drain with count=0 -> out_valid never asserts and state stays COLLECT. in_valid during a DRAIN with in_ready=0 -> sample not stored; subsequent drain contents are unchanged.
- resetn low for one cycle after the first of 4 drain beats -> out_valid=0, count=0, dout=0 next cycle. A new sample 7 then drain -> a single beat of 7 with out_last=1.
